button_conditioner: RTL and testbench

- Input-side front end for the timer switch: turns a raw, asynchronous, bouncy push-button into the clean press/release events that the switch timer consumes.
- Contents: multi-stage synchronizer, per-edge debounce counter, four-state FSM.
- Outputs: a debounced level, one-cycle press/release pulses, and an optional long-press pulse.
- Sits between the board pin and the `btn` input of the switch timer; runs on the same clock.

---
 rtl/button_pkg.sv | 34 +++
 rtl/sync_ff.sv | 35 +++
 rtl/button_conditioner.sv | 176 +++++++++++++++++
 tb/tb_button_conditioner.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : button_pkg
//  Purpose : Shared types, default parameter values and the counter-width
//            helper for the push-button conditioner.
//  Contents:
//    btn_state_t            - four-state debounce FSM encoding
//    DEF_* constants        - default parameter values
//    cnt_width()            - width of the debounce / hold counters
//  Revision: 1.0  initial release
// ============================================================================
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_DEBOUNCE_CYCLES   = 3;
  localparam int DEF_LONG_PRESS_CYCLES = 10;

  // One width serves both counters so they can hold the larger terminal
  // count without wrapping.
  function automatic int cnt_width(input int debounce, input int long_press);
    int m;
    m = (debounce > long_press) ? debounce : long_press;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module  : sync_ff
//  Purpose : N-stage flop chain bringing an asynchronous level into the
//            clock domain. All stages reset asynchronously to 0.
//  Ports   :
//    clock    in   rising-edge clock
//    reset_n  in   asynchronous active-low reset
//    d        in   asynchronous input level
//    q        out  synchronized level (output of last stage)
//  Revision: 1.0  initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module  : button_conditioner
//  Purpose : Turns a raw, bouncy, asynchronous push-button into a clean
//            debounced level plus one-cycle press / release pulses, and an
//            optional long-press pulse.
//  Ports   :
//    clock        in   rising-edge clock
//    reset_n      in   asynchronous active-low reset
//    btn_raw      in   raw button pin (1 = pressed), asynchronous
//    btn_level    out  debounced level (registered)
//    btn_press    out  one-cycle pulse on accepted press
//    btn_release  out  one-cycle pulse on accepted release
//    long_press   out  one-cycle pulse after a sustained press
//  Build option:
//    BUTTON_LONG_PRESS_EN  - when defined, adds the hold counter that drives
//                            long_press; otherwise long_press is tied 0.
//  Revision: 1.0  initial release
// ============================================================================
module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic long_press
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             s;
  btn_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             level_next, press_next, release_next;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (s)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state logic. A WAIT state counts consecutive samples of the new
  // level; when the count would reach DEBOUNCE_CYCLES the change is accepted
  // on that same edge. With DEBOUNCE_CYCLES = 1 the first differing sample
  // is accepted directly from the stable state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          if (ONE >= DEB_MAX) begin
            state_next = PRESSED;
            cnt_next   = '0;
            press_next = 1'b1;
          end else begin
            state_next = PRESS_WAIT;
            cnt_next   = ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_inc >= DEB_MAX) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next   = cnt_inc;
        end
      end
      PRESSED: begin
        if (!s) begin
          if (ONE >= DEB_MAX) begin
            state_next   = IDLE;
            cnt_next     = '0;
            release_next = 1'b1;
          end else begin
            state_next = RELEASE_WAIT;
            cnt_next   = ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_inc >= DEB_MAX) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          cnt_next     = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(LONG_PRESS_CYCLES);

  logic [CNT_W-1:0] hold, hold_next;
  logic             long_next;

  // The hold counter stops at LONG_PRESS_CYCLES, so the pulse can fire only
  // once per accepted press; a bounce back from RELEASE_WAIT keeps the count.
  always_comb begin
    hold_next = hold;
    long_next = 1'b0;
    if (press_next || release_next) begin
      hold_next = '0;
    end else if ((state == PRESSED) || (state == RELEASE_WAIT)) begin
      if (hold < LP_MAX) begin
        hold_next = hold + 1'b1;
        long_next = ((hold + 1'b1) == LP_MAX);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      hold       <= hold_next;
      long_press <= long_next;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module  : tb_button_conditioner
//  Purpose : Directed self-checking bench for button_conditioner at default
//            parameters. Each scenario drives btn_raw from a character
//            pattern (one character per clock, applied before edge i+1) and
//            records when pulses appear; the results are compared against
//            hand-computed edge numbers.
//  Revision: 1.0  initial release
// ============================================================================
module tb_button_conditioner;

  logic clock = 1'b0;
  logic reset_n;
  logic btn_raw;
  logic btn_level, btn_press, btn_release, long_press;

`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  button_conditioner dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .long_press  (long_press)
  );

  always #5 clock = ~clock;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Per-scenario observations (edge numbers are 1-based, -1 = never seen)
  int n_press, t_press, n_rel, t_rel, n_long, t_long, n_lvl, n_both;
  int end_lvl;

  task automatic run_seq(input string pat);
    n_press = 0; t_press = -1;
    n_rel   = 0; t_rel   = -1;
    n_long  = 0; t_long  = -1;
    n_lvl   = 0; n_both  = 0;
    for (int i = 0; i < pat.len(); i++) begin
      btn_raw = (pat[i] == "1");
      @(posedge clock);
      #1;
      if (btn_press) begin
        n_press++;
        if (t_press < 0) t_press = i + 1;
      end
      if (btn_release) begin
        n_rel++;
        if (t_rel < 0) t_rel = i + 1;
      end
      if (long_press) begin
        n_long++;
        if (t_long < 0) t_long = i + 1;
      end
      if (btn_level) n_lvl++;
      if (btn_press && btn_release) n_both++;
    end
    end_lvl = int'(btn_level);
  endtask

  initial begin
    reset_n = 1'b1;
    btn_raw = 1'b0;
    #2 reset_n = 1'b0;

    // 1. Reset held with the button pressed: outputs stay 0 throughout.
    btn_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("rst_outs", int'({btn_level, btn_press, btn_release, long_press}), 0);
    end
    @(negedge clock) reset_n = 1'b1;
    run_seq("11111111111100000000");
    check("s1_press_n", n_press, 1);
    check("s1_press_t", t_press, 5);
    check("s1_rel_t",   t_rel,   17);
    check("s1_lvl_n",   n_lvl,   12);
    check("s1_long_n",  n_long,  LP_EN ? 1 : 0);
    check("s1_long_t",  t_long,  LP_EN ? 15 : -1);

    // 2. Clean press of 10 cycles.
    run_seq("11111111110000000000");
    check("s2_press_t", t_press, 5);
    check("s2_rel_n",   n_rel,   1);
    check("s2_rel_t",   t_rel,   15);
    check("s2_lvl_n",   n_lvl,   10);
    check("s2_long_n",  n_long,  0);
    check("s2_both",    n_both,  0);

    // 3a. Glitches too short to be accepted.
    run_seq("1011000000000");
    check("s3a_press_n", n_press, 0);
    check("s3a_rel_n",   n_rel,   0);
    check("s3a_lvl_n",   n_lvl,   0);

    // 3b. Bounce then a stable press: exactly one press, delayed by the bounce.
    run_seq("11011111111100000000");
    check("s3b_press_n", n_press, 1);
    check("s3b_press_t", t_press, 8);
    check("s3b_rel_t",   t_rel,   17);
    check("s3b_lvl_n",   n_lvl,   9);

    // 4. Release bounce while pressed: level never drops until the real release.
    run_seq("111110011111110000000000");
    check("s4_press_n", n_press, 1);
    check("s4_rel_n",   n_rel,   1);
    check("s4_rel_t",   t_rel,   19);
    check("s4_lvl_n",   n_lvl,   14);
    check("s4_long_n",  n_long,  LP_EN ? 1 : 0);
    check("s4_long_t",  t_long,  LP_EN ? 15 : -1);

    // 5a. Long hold of 20 cycles.
    run_seq("111111111111111111110000000000");
    check("s5a_press_t", t_press, 5);
    check("s5a_rel_t",   t_rel,   25);
    check("s5a_long_n",  n_long,  LP_EN ? 1 : 0);
    check("s5a_long_t",  t_long,  LP_EN ? 15 : -1);
    check("s5a_both",    n_both,  0);

    // 5b. Short hold of 6 cycles: no long press.
    run_seq("1111110000000000");
    check("s5b_press_t", t_press, 5);
    check("s5b_rel_t",   t_rel,   11);
    check("s5b_long_n",  n_long,  0);

    // 6. Reset two cycles after the press while still held.
    run_seq("1111111");
    check("s6_press_t", t_press, 5);
    check("s6_lvl_end", end_lvl, 1);
    reset_n = 1'b0;
    #1;
    check("s6_async_lvl", int'(btn_level), 0);
    check("s6_async_outs", int'({btn_level, btn_press, btn_release, long_press}), 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    run_seq("11111111111100000000");
    check("s6_press_n", n_press, 1);
    check("s6_press_t", t_press, 5);
    check("s6_rel_t",   t_rel,   17);
    check("s6_long_n",  n_long,  LP_EN ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
